// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk -- Galois-LFSR PRBS generator and checker.
//
// Generator side: an N-bit LFSR emits S bits per accepted beat on a
// valid/ready stream. o_valid is the registered run flag, o_data is the
// next S-bit word derived combinationally from the generator state.
// Checker side: an identical LFSR advances once per received word; a
// HUNT/LOCKED FSM tracks alignment and word errors are counted while locked.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_load, i_seed       load seed into both LFSRs, reset checker FSM
//   i_start, i_stop      set / clear generator run flag (stop wins)
//   o_valid, i_ready     generator handshake
//   o_data [S]           generator word, o_data[S-1] is the first bit
//   i_chk_valid          checker word strobe
//   i_chk_data [S]       checker word
//   i_clr_err            zero the error counter
//   o_locked             checker is LOCKED
//   o_err_cnt [ERR_W]    saturating word-error count
module prbs_gen_chk #(
   parameter int             N        = 8,
   parameter logic [N-1:0]   POLY     = 'h1D,
   parameter int             S        = 4,
   parameter int             LOCK_CNT = 4,
   parameter int             ERR_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [N-1:0]     i_seed,
   input  logic             i_start,
   input  logic             i_stop,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [S-1:0]     o_data,
   input  logic             i_chk_valid,
   input  logic [S-1:0]     i_chk_data,
   input  logic             i_clr_err,
   output logic             o_locked,
   output logic [ERR_W-1:0] o_err_cnt
);

   localparam int CW = $clog2(LOCK_CNT + 1);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic {HUNT, LOCKED} state_t;

   // single Galois step
   function automatic logic [N-1:0] step(input logic [N-1:0] st);
      return {st[N-2:0], 1'b0} ^ (POLY & {N{st[N-1]}});
   endfunction

   // S emitted bits, first bit lands in the MSB
   function automatic logic [S-1:0] word_of(input logic [N-1:0] st);
      logic [N-1:0] s;
      logic [S-1:0] w;
      s = st;
      w = '0;
      for (int i = 0; i < S; i++) begin
         w = (w << 1) | S'(s[N-1]);
         s = step(s);
      end
      return w;
   endfunction

   // advance S steps; a zero state (lock-up) is forced back to 1
   function automatic logic [N-1:0] adv(input logic [N-1:0] st);
      logic [N-1:0] s;
      s = st;
      for (int i = 0; i < S; i++) s = step(s);
      return (st == '0) ? ONE : s;
   endfunction

   logic [N-1:0] seed_g;
   assign seed_g = (i_seed == '0) ? ONE : i_seed;

   // ---------------- generator ----------------
   logic [N-1:0] gen_st;
   logic         run;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         gen_st <= '0;
         run    <= 1'b0;
      end else begin
         if (i_stop)       run <= 1'b0;
         else if (i_start) run <= 1'b1;
         if (i_load)                gen_st <= seed_g;
         else if (run && i_ready)   gen_st <= adv(gen_st);
      end
   end

   assign o_valid = run;
   assign o_data  = word_of(gen_st);

   // ---------------- checker ----------------
   logic [N-1:0]     chk_st, chk_n;
   state_t           state, state_n;
   logic [CW-1:0]    match_cnt, match_n, miss_cnt, miss_n;
   logic             hit, err_inc;
   logic [ERR_W-1:0] err_cnt;

   assign hit = (i_chk_data == word_of(chk_st));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         chk_st    <= '0;
         state     <= HUNT;
         match_cnt <= '0;
         miss_cnt  <= '0;
         err_cnt   <= '0;
      end else begin
         chk_st    <= chk_n;
         state     <= state_n;
         match_cnt <= match_n;
         miss_cnt  <= miss_n;
         if (i_clr_err)                     err_cnt <= '0;
         else if (err_inc && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
   end

   always_comb begin
      chk_n   = chk_st;
      state_n = state;
      match_n = match_cnt;
      miss_n  = miss_cnt;
      err_inc = 1'b0;
      if (i_load) begin
         // load takes the cycle: no word is checked
         chk_n   = seed_g;
         state_n = HUNT;
         match_n = '0;
         miss_n  = '0;
      end else if (i_chk_valid) begin
         // state advances on every word so a single bad word cannot slip alignment
         chk_n = adv(chk_st);
         case (state)
            HUNT: begin
               if (!hit) begin
                  match_n = '0;
               end else if (match_cnt == CW'(LOCK_CNT - 1)) begin
                  state_n = LOCKED;
                  match_n = '0;
                  miss_n  = '0;
               end else begin
                  match_n = match_cnt + 1'b1;
               end
            end
            LOCKED: begin
               if (hit) begin
                  miss_n = '0;
               end else begin
                  err_inc = 1'b1;
                  if (miss_cnt == CW'(LOCK_CNT - 1)) begin
                     state_n = HUNT;
                     match_n = '0;
                     miss_n  = '0;
                  end else begin
                     miss_n = miss_cnt + 1'b1;
                  end
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   assign o_locked  = (state == LOCKED);
   assign o_err_cnt = err_cnt;

endmodule
